// File: rtl/vx_issue_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vx_issue_pkg
// Desc   : Shared types, widths and helpers for the issue stage.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
package vx_issue_pkg;

  // Default configuration of the issue stage
  localparam int NUM_THREADS_DEF = 4;
  localparam int NUM_REGS_DEF    = 64;
  localparam int NUM_EX_DEF      = 5;
  localparam int REG_W           = $clog2(NUM_REGS_DEF);
  localparam int EX_W            = $clog2(NUM_EX_DEF);

  // Execute-unit types
  typedef enum logic [EX_W-1:0] {
    EX_ALU = 3'd0,
    EX_LSU = 3'd1,
    EX_CSR = 3'd2,
    EX_FPU = 3'd3,
    EX_GPU = 3'd4
  } ex_type_t;

  // One decoded instruction as presented on a warp slot
  typedef struct packed {
    logic [NUM_THREADS_DEF-1:0] tmask;
    ex_type_t                   ex;
    logic                       wb;
    logic [REG_W-1:0]           rd;
    logic [REG_W-1:0]           rs1;
    logic [REG_W-1:0]           rs2;
    logic [REG_W-1:0]           rs3;
  } issue_slot_t;

  // Number of set bits in a (zero-extended) mask of up to 64 bits
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_rr_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vx_rr_picker
// Desc   : Combinational round-robin picker. Selects the first requester at
//          or after ptr (wrapping) and reports it one-hot and as an index.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
module vx_rr_picker
  import vx_issue_pkg::*;
#(
  parameter int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Scan N positions starting at ptr; the first active request wins
  always_comb begin
    logic [IDX_W-1:0] w_idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IDX_W'((int'(ptr) + i) % N);
      if (!grant_valid && req[w_idx]) begin
        grant_valid  = 1'b1;
        grant_idx    = w_idx;
        grant[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_issue_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vx_issue_sched
// Desc   : Multi-slot issue scheduler. Per-slot register scoreboard, round-
//          robin pick of one hazard-free slot per cycle, registered output
//          stage towards the execute units, issue perf counters.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
module vx_issue_sched
  import vx_issue_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int NUM_REGS    = 64,
  parameter int NUM_EX      = 5,
  parameter int CTR_W       = 44,
  localparam int REG_BITS   = $clog2(NUM_REGS),
  localparam int EX_BITS    = $clog2(NUM_EX),
  localparam int SLOT_BITS  = $clog2(NUM_SLOTS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_SLOTS-1:0]           in_valid,
  output logic [NUM_SLOTS-1:0]           in_ready,
  input  logic [NUM_SLOTS*NUM_THREADS-1:0] in_tmask,
  input  logic [NUM_SLOTS*EX_BITS-1:0]   in_ex,
  input  logic [NUM_SLOTS-1:0]           in_wb,
  input  logic [NUM_SLOTS*REG_BITS-1:0]  in_rd,
  input  logic [NUM_SLOTS*REG_BITS-1:0]  in_rs1,
  input  logic [NUM_SLOTS*REG_BITS-1:0]  in_rs2,
  input  logic [NUM_SLOTS*REG_BITS-1:0]  in_rs3,
  input  logic                           wb_valid,
  input  logic [SLOT_BITS-1:0]           wb_slot,
  input  logic [REG_BITS-1:0]            wb_rd,
  input  logic                           wb_eop,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SLOT_BITS-1:0]           out_slot,
  output logic [NUM_THREADS-1:0]         out_tmask,
  output logic [EX_BITS-1:0]             out_ex,
  output logic [REG_BITS-1:0]            out_rd,
  output logic                           out_wb,
  output logic [CTR_W-1:0]               perf_active_threads,
  output logic [CTR_W-1:0]               perf_scb_stalls,
  output logic [NUM_EX*CTR_W-1:0]        perf_unit_stalls
);

  localparam logic [EX_BITS-1:0]   c_ex_last   = EX_BITS'(NUM_EX - 1);
  localparam logic [SLOT_BITS-1:0] c_slot_last = SLOT_BITS'(NUM_SLOTS - 1);

  logic [NUM_THREADS-1:0] w_tmask [NUM_SLOTS];
  logic [EX_BITS-1:0]     w_ex    [NUM_SLOTS];
  logic [REG_BITS-1:0]    w_rd    [NUM_SLOTS];
  logic [REG_BITS-1:0]    w_rs1   [NUM_SLOTS];
  logic [REG_BITS-1:0]    w_rs2   [NUM_SLOTS];
  logic [REG_BITS-1:0]    w_rs3   [NUM_SLOTS];

  logic [NUM_REGS-1:0]    r_busy  [NUM_SLOTS];
  logic [SLOT_BITS-1:0]   r_rr_ptr;
  logic [CTR_W-1:0]       r_unit_stalls [NUM_EX];

  logic [NUM_SLOTS-1:0]   w_hazard;
  logic [NUM_SLOTS-1:0]   w_eligible;
  logic [NUM_SLOTS-1:0]   w_req;
  logic [NUM_SLOTS-1:0]   w_grant;
  logic [SLOT_BITS-1:0]   w_grant_idx;
  logic                   w_grant_valid;
  logic                   w_can_load;
  logic                   w_scb_stall;
  logic [EX_BITS-1:0]     w_unit_idx;

  logic [NUM_THREADS-1:0] w_sel_tmask;
  logic [EX_BITS-1:0]     w_sel_ex;
  logic [REG_BITS-1:0]    w_sel_rd;
  logic                   w_sel_wb;

  // Unpack per-slot fields and evaluate hazards against the registered scoreboard
  generate
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      assign w_tmask[s] = in_tmask[s*NUM_THREADS +: NUM_THREADS];
      assign w_ex[s]    = in_ex[s*EX_BITS +: EX_BITS];
      assign w_rd[s]    = in_rd[s*REG_BITS +: REG_BITS];
      assign w_rs1[s]   = in_rs1[s*REG_BITS +: REG_BITS];
      assign w_rs2[s]   = in_rs2[s*REG_BITS +: REG_BITS];
      assign w_rs3[s]   = in_rs3[s*REG_BITS +: REG_BITS];
      assign w_hazard[s] = r_busy[s][w_rs1[s]] | r_busy[s][w_rs2[s]] | r_busy[s][w_rs3[s]]
                         | (in_wb[s] & r_busy[s][w_rd[s]]);
    end
  endgenerate

  assign w_eligible = in_valid & ~w_hazard;
  assign w_can_load = ~out_valid | out_ready;
  // Nothing is offered while reset is asserted
  assign w_req      = w_eligible & {NUM_SLOTS{w_can_load & reset_n}};
  assign in_ready   = w_grant;

  assign w_scb_stall = (|in_valid) & ~(|w_eligible) & (|(in_valid & w_hazard));

  vx_rr_picker #(.N(NUM_SLOTS)) u_picker (
    .req         (w_req),
    .ptr         (r_rr_ptr),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  assign w_sel_tmask = w_tmask[w_grant_idx];
  assign w_sel_ex    = w_ex[w_grant_idx];
  assign w_sel_rd    = w_rd[w_grant_idx];
  assign w_sel_wb    = in_wb[w_grant_idx];

  // Out-of-range unit codes are accounted on the last unit
  assign w_unit_idx = (out_ex > c_ex_last) ? c_ex_last : out_ex;

  // Round-robin pointer advances past each winner, holds otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant_valid) begin
      r_rr_ptr <= (w_grant_idx == c_slot_last) ? '0 : w_grant_idx + SLOT_BITS'(1);
    end
  end

  // Output stage: load on grant, drop when drained with nothing new, else hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_slot  <= '0;
      out_tmask <= '0;
      out_ex    <= '0;
      out_rd    <= '0;
      out_wb    <= 1'b0;
    end else if (w_grant_valid) begin
      out_valid <= 1'b1;
      out_slot  <= w_grant_idx;
      out_tmask <= w_sel_tmask;
      out_ex    <= w_sel_ex;
      out_rd    <= w_sel_rd;
      out_wb    <= w_sel_wb;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Scoreboard: release on final writeback beat, reserve rd on issue (x0 never reserved)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_busy[s] <= '0;
      end
    end else begin
      if (wb_valid && wb_eop) begin
        r_busy[wb_slot][wb_rd] <= 1'b0;
      end
      if (w_grant_valid && w_sel_wb && (w_sel_rd != '0)) begin
        r_busy[w_grant_idx][w_sel_rd] <= 1'b1;
      end
    end
  end

  // Issue-side perf counters: active threads per grant and hazard-blocked cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_active_threads <= '0;
      perf_scb_stalls     <= '0;
    end else begin
      if (w_grant_valid) begin
        perf_active_threads <= perf_active_threads + CTR_W'(popcount(64'(w_sel_tmask)));
      end
      if (w_scb_stall) begin
        perf_scb_stalls <= perf_scb_stalls + CTR_W'(1);
      end
    end
  end

  // Per-unit backpressure counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int u = 0; u < NUM_EX; u++) begin
        r_unit_stalls[u] <= '0;
      end
    end else if (out_valid && !out_ready) begin
      r_unit_stalls[w_unit_idx] <= r_unit_stalls[w_unit_idx] + CTR_W'(1);
    end
  end

  generate
    for (genvar u = 0; u < NUM_EX; u++) begin : g_unit
      assign perf_unit_stalls[u*CTR_W +: CTR_W] = r_unit_stalls[u];
    end
  endgenerate

  a_ex_legal: assert property (@(posedge clk) disable iff (!reset_n)
                               out_valid |-> (out_ex <= c_ex_last));

endmodule
`default_nettype wire

// File: tb/tb_vx_issue_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_vx_issue_sched
// Desc   : Directed self-checking bench for vx_issue_sched.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_vx_issue_sched;

  localparam int CW = 44;

  logic        clk;
  logic        reset_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] in_tmask;
  logic [11:0] in_ex;
  logic [3:0]  in_wb;
  logic [23:0] in_rd, in_rs1, in_rs2, in_rs3;
  logic        wb_valid;
  logic [1:0]  wb_slot;
  logic [5:0]  wb_rd;
  logic        wb_eop;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_slot;
  logic [3:0]  out_tmask;
  logic [2:0]  out_ex;
  logic [5:0]  out_rd;
  logic        out_wb;
  logic [CW-1:0]   perf_active_threads;
  logic [CW-1:0]   perf_scb_stalls;
  logic [5*CW-1:0] perf_unit_stalls;

  int checks   = 0;
  int failures = 0;

  vx_issue_sched dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_tmask            (in_tmask),
    .in_ex               (in_ex),
    .in_wb               (in_wb),
    .in_rd               (in_rd),
    .in_rs1              (in_rs1),
    .in_rs2              (in_rs2),
    .in_rs3              (in_rs3),
    .wb_valid            (wb_valid),
    .wb_slot             (wb_slot),
    .wb_rd               (wb_rd),
    .wb_eop              (wb_eop),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_slot            (out_slot),
    .out_tmask           (out_tmask),
    .out_ex              (out_ex),
    .out_rd              (out_rd),
    .out_wb              (out_wb),
    .perf_active_threads (perf_active_threads),
    .perf_scb_stalls     (perf_scb_stalls),
    .perf_unit_stalls    (perf_unit_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in_valid;
    logic       out_ready;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_slot;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic [3:0] tm, input logic [2:0] ex,
                          input logic wb, input logic [5:0] rd, input logic [5:0] rs1,
                          input logic [5:0] rs2, input logic [5:0] rs3);
    in_tmask[s*4 +: 4] = tm;
    in_ex[s*3 +: 3]    = ex;
    in_wb[s]           = wb;
    in_rd[s*6 +: 6]    = rd;
    in_rs1[s*6 +: 6]   = rs1;
    in_rs2[s*6 +: 6]   = rs2;
    in_rs3[s*6 +: 6]   = rs3;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_tmask = '0; in_ex = '0; in_wb = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    wb_valid = 1'b0; wb_slot = '0; wb_rd = '0; wb_eop = 1'b0;
    out_ready = 1'b1;
  endtask

  // Advance one clock; returns at the falling edge so inputs change away from posedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    #1;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    // Table: all slots valid & hazard-free; round-robin order, hold, drain, wrap
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b0, 2'd1};
    tbl[10] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2};

    // ---- Reset with all slots valid ----
    reset_n = 1'b0;
    clear_inputs();
    in_valid = 4'b1111;
    cyc();
    #1;
    check("reset_in_ready", in_ready, 4'b0000);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_active", perf_active_threads, 0);
    check("reset_scb", perf_scb_stalls, 0);
    check("reset_unit", perf_unit_stalls, 0);
    check("reset_out_slot", out_slot, 2'd0);

    // ---- Round-robin table ----
    set_slot(0, 4'b0001, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    set_slot(1, 4'b0011, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    set_slot(2, 4'b0111, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    set_slot(3, 4'b1111, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid  = tbl[i].in_valid;
      out_ready = tbl[i].out_ready;
      #1;
      check($sformatf("rr%0d_in_ready", i), in_ready, tbl[i].exp_ready);
      check($sformatf("rr%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      check($sformatf("rr%0d_out_slot", i), out_slot, tbl[i].exp_slot);
      cyc();
    end
    #1;
    check("rr_active_threads", perf_active_threads, 17);
    check("rr_unit_alu", perf_unit_stalls[0*CW +: CW], 1);
    check("rr_scb", perf_scb_stalls, 0);

    // ---- RAW on slot 1 ----
    do_reset();
    set_slot(1, 4'b1111, 3'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
    in_valid = 4'b0010;
    #1;
    check("raw_first_issue", in_ready, 4'b0010);
    cyc();
    set_slot(1, 4'b1111, 3'd0, 1'b1, 6'd6, 6'd5, 6'd0, 6'd0);
    #1;
    check("raw_blocked", in_ready, 4'b0000);
    cyc();
    wb_valid = 1'b1; wb_slot = 2'd1; wb_rd = 6'd5; wb_eop = 1'b0;
    #1;
    check("raw_scb_1", perf_scb_stalls, 1);
    check("raw_noneop_blocked", in_ready, 4'b0000);
    cyc();
    wb_eop = 1'b1;
    #1;
    check("raw_eop_no_bypass", in_ready, 4'b0000);
    cyc();
    wb_valid = 1'b0; wb_eop = 1'b0;
    #1;
    check("raw_released", in_ready, 4'b0010);
    check("raw_scb_3", perf_scb_stalls, 3);
    cyc();

    // ---- x0 destination and WAW on slot 2 ----
    in_valid = 4'b0100;
    set_slot(2, 4'b0001, 3'd0, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0);
    #1;
    check("x0_writer", in_ready, 4'b0100);
    cyc();
    set_slot(2, 4'b0001, 3'd0, 1'b0, 6'd3, 6'd0, 6'd0, 6'd0);
    #1;
    check("x0_dependant", in_ready, 4'b0100);
    cyc();
    set_slot(2, 4'b0001, 3'd0, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0);
    #1;
    check("waw_first", in_ready, 4'b0100);
    cyc();
    wb_valid = 1'b1; wb_slot = 2'd1; wb_rd = 6'd7; wb_eop = 1'b1;
    #1;
    check("waw_blocked", in_ready, 4'b0000);
    cyc();
    wb_slot = 2'd2;
    #1;
    check("waw_other_slot_no_release", in_ready, 4'b0000);
    cyc();
    wb_valid = 1'b0; wb_eop = 1'b0;
    #1;
    check("waw_released", in_ready, 4'b0100);
    cyc();
    in_valid = 4'b0000;

    // ---- Backpressure on LSU, popcount ----
    do_reset();
    set_slot(0, 4'b1011, 3'd1, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0);
    in_valid = 4'b0001;
    #1;
    check("bp_issue", in_ready, 4'b0001);
    cyc();
    set_slot(3, 4'b0110, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
      check($sformatf("bp%0d_out_slot", i), out_slot, 2'd0);
      check($sformatf("bp%0d_out_ex", i), out_ex, 3'd1);
      check($sformatf("bp%0d_out_tmask", i), out_tmask, 4'b1011);
      check($sformatf("bp%0d_out_rd", i), out_rd, 6'd9);
      check($sformatf("bp%0d_out_wb", i), out_wb, 1'b1);
      check($sformatf("bp%0d_in_ready", i), in_ready, 4'b0000);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("bp_unit_lsu", perf_unit_stalls[1*CW +: CW], 3);
    check("bp_resume_grant", in_ready, 4'b1000);
    cyc();
    in_valid = 4'b0000;
    #1;
    check("bp_next_slot", out_slot, 2'd3);
    check("bp_next_tmask", out_tmask, 4'b0110);
    check("pop_active_threads", perf_active_threads, 5);
    check("bp_unit_alu_zero", perf_unit_stalls[0*CW +: CW], 0);

    // ---- Async reset in the middle of a stall ----
    out_ready = 1'b0;
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_active", perf_active_threads, 0);
    check("areset_unit", perf_unit_stalls, 0);
    cyc();
    reset_n = 1'b1;
    out_ready = 1'b1;
    set_slot(0, 4'b0001, 3'd0, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0);
    in_valid = 4'b0001;
    #1;
    check("areset_busy_cleared", in_ready, 4'b0001);
    cyc();
    in_valid = 4'b0000;
    #1;
    check("areset_reissue_valid", out_valid, 1'b1);
    check("areset_reissue_slot", out_slot, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
